neopixel_tx: RTL

- Downstream consumer of the LED frame double buffer. Reads one frame's bytes through the buffer's read port and serialises them onto a single WS2812-style NeoPixel data line.
- Starts a frame on the buffer's frame-valid pulse and ends each frame with a latch (reset) low period.
- Output pin is driven directly from a register.

---
 rtl/neopixel_pkg.sv | 25 ++
 rtl/neopixel_tx_if.sv | 11 +
 rtl/neopixel_bit_timer.sv | 43 ++++
 rtl/neopixel_tx.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/neopixel_pkg.sv
// Shared types, 12 MHz timing defaults and helpers for the NeoPixel transmitter.
package neopixel_pkg;

    typedef enum logic [1:0] {IDLE, LOAD, BITS, LATCH} state_e;

    localparam int unsigned T_BIT_DEF     = 15;
    localparam int unsigned T0H_DEF       = 4;
    localparam int unsigned T1H_DEF       = 8;
    localparam int unsigned T_RESET_DEF   = 3600;
    localparam int unsigned BYTES_PER_LED = 3;
    localparam int unsigned BITS_PER_BYTE = 8;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    // Scale a byte by (level+1)/256; level 255 passes the byte through unchanged.
    function automatic logic [7:0] scale_byte(input logic [7:0] data, input logic [7:0] level);
        logic [15:0] prod;
        prod = 16'(data) * (16'(level) + 16'd1);
        return prod[15:8];
    endfunction

endpackage

// File: rtl/neopixel_tx_if.sv
// Read port between the LED frame double buffer (master) and the transmitter (slave).
interface neopixel_tx_if #(
    parameter int unsigned ADDR_WIDTH = 7
);
    logic                  i_frame_valid;
    logic [ADDR_WIDTH-1:0] o_rd_addr;
    logic [7:0]            i_rd_data;

    modport master (output i_frame_valid, output i_rd_data, input  o_rd_addr);
    modport slave  (input  i_frame_valid, input  i_rd_data, output o_rd_addr);
endinterface

// File: rtl/neopixel_bit_timer.sv
// One-bit waveform generator: registered high/low level over a T_BIT slot plus end-of-slot strobe.
module neopixel_bit_timer
    import neopixel_pkg::*;
#(
    parameter int unsigned T_BIT = T_BIT_DEF,
    parameter int unsigned T0H   = T0H_DEF,
    parameter int unsigned T1H   = T1H_DEF
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic start_i,
    input  logic run_i,
    input  logic bit_i,
    output logic dout_o,
    output logic bit_end_o_c
);
    localparam int unsigned CW = cnt_w(T_BIT);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic [CW-1:0] high_c;

    assign bit_end_o_c = run_i && (cnt_q == CW'(T_BIT - 1));
    assign high_c      = bit_i ? CW'(T1H) : CW'(T0H);

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (start_i || !run_i || bit_end_o_c) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            cnt_q  <= '0;
            dout_o <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            dout_o <= run_i && !start_i && (cnt_q < high_c);
        end
    end

endmodule

// File: rtl/neopixel_tx.sv
// WS2812 frame serialiser reading bytes from the frame buffer read port.
// Optional NEOPIXEL_TX_BRIGHTNESS_EN adds a per-frame brightness scaler on i_brightness.
module neopixel_tx
    import neopixel_pkg::*;
#(
    parameter int unsigned LEDS       = 30,
    parameter int unsigned ADDR_WIDTH = $clog2(LEDS * BYTES_PER_LED),
    parameter int unsigned T_BIT      = T_BIT_DEF,
    parameter int unsigned T0H        = T0H_DEF,
    parameter int unsigned T1H        = T1H_DEF,
    parameter int unsigned T_RESET    = T_RESET_DEF
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
`ifdef NEOPIXEL_TX_BRIGHTNESS_EN
    input  logic [7:0]    i_brightness,
`endif
    neopixel_tx_if.slave  bus,
    output logic          o_dout,
    output logic          o_busy,
    output logic          o_frame_done
);
    localparam int unsigned NBYTES = LEDS * BYTES_PER_LED;
    localparam int unsigned BYTE_W = cnt_w(NBYTES);
    localparam int unsigned BIT_W  = cnt_w(BITS_PER_BYTE);
    localparam int unsigned LAT_W  = cnt_w(T_RESET);

    state_e                state_q;
    logic [7:0]            shift_q;
    logic [BIT_W-1:0]      bit_q;
    logic [BYTE_W-1:0]     byte_q;
    logic [LAT_W-1:0]      lat_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  pend_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  bit_end_c;
    logic [7:0]            load_byte_c;

`ifdef NEOPIXEL_TX_BRIGHTNESS_EN
    logic [7:0] bright_q;
    // Byte 0 is loaded in the same cycle the level is captured, so use the live port then.
    assign load_byte_c = scale_byte(bus.i_rd_data, (state_q == LOAD) ? i_brightness : bright_q);
`else
    assign load_byte_c = bus.i_rd_data;
`endif

    neopixel_bit_timer #(
        .T_BIT (T_BIT),
        .T0H   (T0H),
        .T1H   (T1H)
    ) u_bit_timer (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .start_i     (state_q == LOAD),
        .run_i       (state_q == BITS),
        .bit_i       (shift_q[7]),
        .dout_o      (o_dout),
        .bit_end_o_c (bit_end_c)
    );

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q  <= IDLE;
            shift_q  <= '0;
            bit_q    <= '0;
            byte_q   <= '0;
            lat_q    <= '0;
            addr_q   <= '0;
            pend_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef NEOPIXEL_TX_BRIGHTNESS_EN
            bright_q <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            if (bus.i_frame_valid && (state_q != IDLE)) begin
                pend_q <= 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (bus.i_frame_valid || pend_q) begin
                        state_q <= LOAD;
                        busy_q  <= 1'b1;
                        pend_q  <= 1'b0;
                    end
                end
                LOAD: begin
                    shift_q  <= load_byte_c;
                    bit_q    <= '0;
                    byte_q   <= '0;
                    addr_q   <= '0;
`ifdef NEOPIXEL_TX_BRIGHTNESS_EN
                    bright_q <= i_brightness;
`endif
                    state_q  <= BITS;
                end
                BITS: begin
                    if (bit_end_c) begin
                        if (bit_q == BIT_W'(BITS_PER_BYTE - 1)) begin
                            bit_q <= '0;
                            if (byte_q == BYTE_W'(NBYTES - 1)) begin
                                state_q <= LATCH;
                                addr_q  <= '0;
                                lat_q   <= '0;
                            end else begin
                                shift_q <= load_byte_c;
                                byte_q  <= byte_q + BYTE_W'(1);
                            end
                        end else begin
                            shift_q <= {shift_q[6:0], 1'b0};
                            bit_q   <= bit_q + BIT_W'(1);
                            // Present the next byte's address for the whole of bit 7.
                            if ((bit_q == BIT_W'(BITS_PER_BYTE - 2)) &&
                                (byte_q != BYTE_W'(NBYTES - 1))) begin
                                addr_q <= ADDR_WIDTH'(byte_q) + ADDR_WIDTH'(1);
                            end
                        end
                    end
                end
                LATCH: begin
                    if (lat_q == LAT_W'(T_RESET - 1)) begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        lat_q <= lat_q + LAT_W'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.o_rd_addr = addr_q;
    assign o_busy        = busy_q;
    assign o_frame_done  = done_q;

endmodule
